// File: rtl/mode_sequencer.sv
// Video mode sequencer: a debounced button press steps through four video modes,
// switching on a vsync edge (or after a timeout) with blanking and a timing-generator reset.
module mode_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SETTLE_CYCLES   = 4096,
    parameter int unsigned VS_TIMEOUT      = 4000000
) (
    input  logic       sys_clk,
    input  logic       act_reset,
    input  logic       but_center,
    input  logic       vsync_in,
    output logic [1:0] mode_sel,
    output logic       mode_load,
    output logic       vid_reset,
    output logic       blank,
    output logic       busy,
    output logic       timeout_flag
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned VS_W = $clog2(VS_TIMEOUT + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [VS_W-1:0] VS_LAST = VS_W'(VS_TIMEOUT - 1);

    localparam logic [2:0] INIT    = 3'd0;
    localparam logic [2:0] IDLE    = 3'd1;
    localparam logic [2:0] WAIT_VS = 3'd2;
    localparam logic [2:0] SWITCH  = 3'd3;
    localparam logic [2:0] LOAD    = 3'd4;
    localparam logic [2:0] SETTLE  = 3'd5;
    localparam logic [2:0] RELEASE = 3'd6;

    logic [2:0]      state;
    logic [1:0]      but_sync;
    logic [1:0]      vs_sync;
    logic            db_level;
    logic            db_prev;
    logic [DB_W-1:0] db_cnt;
    logic            vs_prev;
    logic [VS_W-1:0] wait_cnt;
    logic [ST_W-1:0] settle_cnt;
    logic            but_s;
    logic            vs_s;
    logic            press;
    logic            vs_edge;

    assign but_s   = but_sync[1];
    assign vs_s    = vs_sync[1];
    assign press   = db_level & ~db_prev;
    assign vs_edge = vs_s & ~vs_prev;

    always_ff @(posedge sys_clk or posedge act_reset) begin
        if (act_reset) begin
            but_sync <= '0;
            vs_sync  <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            but_sync <= {but_sync[0], but_center};
            vs_sync  <= {vs_sync[0], vsync_in};
            db_prev  <= db_level;
            if (but_s != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= but_s;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge act_reset) begin
        if (act_reset) begin
            state        <= INIT;
            mode_sel     <= '0;
            timeout_flag <= 1'b0;
            vs_prev      <= 1'b0;
            wait_cnt     <= '0;
            settle_cnt   <= '0;
        end else begin
            // Outside WAIT_VS the edge history reads as high, so a level already high on entry is ignored
            vs_prev <= (state == WAIT_VS) ? vs_s : 1'b1;
            case (state)
                INIT: state <= LOAD;
                IDLE: begin
                    wait_cnt <= '0;
                    if (press) state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (vs_edge) begin
                        state    <= SWITCH;
                        wait_cnt <= '0;
                    end else if (wait_cnt == VS_LAST) begin
                        state        <= SWITCH;
                        timeout_flag <= 1'b1;
                        wait_cnt     <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                SWITCH: begin
                    mode_sel <= mode_sel + 2'd1;
                    state    <= LOAD;
                end
                LOAD: begin
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == ST_LAST) begin
                        settle_cnt <= '0;
                        state      <= RELEASE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

    always_comb begin
        mode_load = 1'b0;
        vid_reset = 1'b0;
        blank     = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: ;
            WAIT_VS: begin
                blank = 1'b1;
                busy  = 1'b1;
            end
            LOAD: begin
                mode_load = 1'b1;
                vid_reset = 1'b1;
                blank     = 1'b1;
                busy      = 1'b1;
            end
            RELEASE: begin
                blank = 1'b1;
                busy  = 1'b1;
            end
            default: begin
                vid_reset = 1'b1;
                blank     = 1'b1;
                busy      = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer; every mode_load pulse is matched against a queue
// of expected mode indices filled as presses are issued.
module tb_mode_sequencer;

    logic       sys_clk    = 1'b0;
    logic       act_reset  = 1'b1;
    logic       but_center = 1'b0;
    logic       vsync_in   = 1'b0;
    logic [1:0] mode_sel;
    logic       mode_load;
    logic       vid_reset;
    logic       blank;
    logic       busy;
    logic       timeout_flag;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          load_count = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  mon_exp;
    logic        prev_load = 1'b0;

    always #5 sys_clk = ~sys_clk;

    mode_sequencer #(
        .DEBOUNCE_CYCLES(8),
        .SETTLE_CYCLES  (16),
        .VS_TIMEOUT     (100)
    ) dut (
        .sys_clk     (sys_clk),
        .act_reset   (act_reset),
        .but_center  (but_center),
        .vsync_in    (vsync_in),
        .mode_sel    (mode_sel),
        .mode_load   (mode_load),
        .vid_reset   (vid_reset),
        .blank       (blank),
        .busy        (busy),
        .timeout_flag(timeout_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: each load strobe must be a single cycle and match the next queued mode
    always @(negedge sys_clk) begin
        if (mode_load === 1'b1) begin
            load_count++;
            check("load_width", {31'd0, prev_load}, 0);
            check("load_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("load_mode", {30'd0, mode_sel}, {30'd0, mon_exp});
            end
        end
        prev_load = mode_load;
    end

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check(tag, {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic wait_vid(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (vid_reset !== lvl && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check(tag, {31'd0, vid_reset}, {31'd0, lvl});
    endtask

    task automatic do_switch(input logic [1:0] old_mode);
        int n;
        logic [1:0] nm;
        nm = old_mode + 2'd1;
        exp_q.push_back(nm);
        @(negedge sys_clk);
        but_center = 1'b1;
        wait_busy(1'b1, 40, "sw_busy_rise");
        check("sw_blank_first", {31'd0, blank}, 1);
        check("sw_mode_unchanged", {30'd0, mode_sel}, {30'd0, old_mode});
        check("sw_vidreset_low", {31'd0, vid_reset}, 0);
        but_center = 1'b0;
        repeat (20) @(negedge sys_clk);
        vsync_in = 1'b1;
        wait_vid(1'b1, 20, "sw_vid_rise");
        n = 0;
        while (vid_reset === 1'b1 && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        check("sw_vid_high_len", n, 18);
        vsync_in = 1'b0;
        check("sw_mode_new", {30'd0, mode_sel}, {30'd0, nm});
        wait_busy(1'b0, 5, "sw_busy_fall");
        check("sw_blank_fall", {31'd0, blank}, 0);
        check("sw_no_timeout", {31'd0, timeout_flag}, 0);
    endtask

    initial begin
        int   n;
        logic seen;

        // Reset values
        repeat (3) @(negedge sys_clk);
        check("rst_mode_sel", {30'd0, mode_sel}, 0);
        check("rst_mode_load", {31'd0, mode_load}, 0);
        check("rst_vid_reset", {31'd0, vid_reset}, 1);
        check("rst_blank", {31'd0, blank}, 1);
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_timeout", {31'd0, timeout_flag}, 0);

        // Release: one load with mode 00, vid_reset low 18 cycles later
        exp_q.push_back(2'd0);
        act_reset = 1'b0;
        n = 0;
        while (vid_reset === 1'b1 && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        check("rst_vid_len", n, 18);
        wait_busy(1'b0, 5, "rst_idle");
        check("rst_load_count", load_count, 1);

        // Button high for only 7 cycles
        @(negedge sys_clk);
        but_center = 1'b1;
        repeat (7) @(negedge sys_clk);
        but_center = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge sys_clk);
            if (busy !== 1'b0) seen = 1'b1;
        end
        check("short_press", {31'd0, seen}, 0);

        // Bouncing every 3 cycles
        seen = 1'b0;
        for (int i = 0; i < 42; i++) begin
            if (i % 3 == 0) but_center = ~but_center;
            @(negedge sys_clk);
            if (busy !== 1'b0) seen = 1'b1;
        end
        but_center = 1'b0;
        repeat (20) begin
            @(negedge sys_clk);
            if (busy !== 1'b0) seen = 1'b1;
        end
        check("bounce_press", {31'd0, seen}, 0);

        // Four clean switches with wrap
        do_switch(2'd0);
        do_switch(2'd1);
        do_switch(2'd2);
        do_switch(2'd3);
        check("wrap_mode", {30'd0, mode_sel}, 0);
        check("wrap_load_count", load_count, 5);

        // vsync held high: no edge, timeout after 100 cycles
        vsync_in = 1'b1;
        repeat (5) @(negedge sys_clk);
        exp_q.push_back(2'd1);
        but_center = 1'b1;
        wait_busy(1'b1, 40, "to_busy");
        but_center = 1'b0;
        check("to_flag_before", {31'd0, timeout_flag}, 0);
        n = 0;
        while (vid_reset !== 1'b1 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("to_wait_len", n, 100);
        check("to_flag_set", {31'd0, timeout_flag}, 1);
        wait_busy(1'b0, 40, "to_done");
        check("to_flag_sticky", {31'd0, timeout_flag}, 1);
        check("to_mode", {30'd0, mode_sel}, 1);

        // Second press during SETTLE is discarded
        vsync_in = 1'b0;
        repeat (5) @(negedge sys_clk);
        exp_q.push_back(2'd2);
        but_center = 1'b1;
        wait_busy(1'b1, 40, "p2_busy");
        but_center = 1'b0;
        repeat (20) @(negedge sys_clk);
        vsync_in = 1'b1;
        wait_vid(1'b1, 20, "p2_vid_rise");
        vsync_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        but_center = 1'b1;
        repeat (12) @(negedge sys_clk);
        but_center = 1'b0;
        wait_busy(1'b0, 60, "p2_done");
        seen = 1'b0;
        repeat (30) begin
            @(negedge sys_clk);
            if (busy !== 1'b0) seen = 1'b1;
        end
        check("settle_press_ignored", {31'd0, seen}, 0);
        check("p2_mode", {30'd0, mode_sel}, 2);
        check("p2_flag_sticky", {31'd0, timeout_flag}, 1);

        // Reset during WAIT_VS aborts immediately
        but_center = 1'b1;
        wait_busy(1'b1, 40, "p3_busy");
        but_center = 1'b0;
        repeat (10) @(negedge sys_clk);
        #1 act_reset = 1'b1;
        #1;
        check("abort_mode", {30'd0, mode_sel}, 0);
        check("abort_vid_reset", {31'd0, vid_reset}, 1);
        check("abort_blank", {31'd0, blank}, 1);
        check("abort_busy", {31'd0, busy}, 1);
        check("abort_timeout", {31'd0, timeout_flag}, 0);
        exp_q.push_back(2'd0);
        @(negedge sys_clk);
        act_reset = 1'b0;
        wait_busy(1'b0, 60, "final_idle");
        check("final_load_count", load_count, 8);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
